// File: rtl/accum_mchan_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | accum_mchan_if : sample/result bus of the multi-channel accum.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface accum_mchan_if #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                    valid_i;
  logic [CH_W-1:0]         ch_i;
  logic signed [WIDTH-1:0] x_i;
  logic                    clr_i;
  logic                    valid_o;
  logic [CH_W-1:0]         ch_o;
  logic signed [WIDTH-1:0] y_o;
  logic [CNT_W-1:0]        cnt_o;
  logic [N_CH-1:0]         ovf_o;

  modport master (
    output valid_i, ch_i, x_i, clr_i,
    input  valid_o, ch_o, y_o, cnt_o, ovf_o
  );

  modport slave (
    input  valid_i, ch_i, x_i, clr_i,
    output valid_o, ch_o, y_o, cnt_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/accum_mchan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | accum_mchan : N_CH signed accumulators, wrap or saturate mode.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module accum_mchan #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4,
  parameter int SAT   = 0,
  parameter int CNT_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  accum_mchan_if.slave  bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] acc_q [N_CH];
  logic signed [WIDTH-1:0] acc_d [N_CH];
  logic [CNT_W-1:0]        cnt_q [N_CH];
  logic [CNT_W-1:0]        cnt_d [N_CH];
  logic [N_CH-1:0]         ovf_q, ovf_d;
  logic                    valid_q, valid_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;

  logic                    hit;
  logic signed [WIDTH-1:0] base_acc, new_acc;
  logic [CNT_W-1:0]        base_cnt, new_cnt;
  logic                    base_ovf, ovf_now;
  logic [WIDTH:0]          sum;

  always_comb begin
    hit      = 1'b0;
    base_acc = '0;
    base_cnt = '0;
    base_ovf = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (32'(bus.ch_i) == k) begin
        hit      = 1'b1;
        base_acc = acc_q[k];
        base_cnt = cnt_q[k];
        base_ovf = ovf_q[k];
      end
    end
    // A fused clear restarts the channel from zero, so the sample becomes the result.
    if (bus.clr_i) begin
      base_acc = '0;
      base_cnt = '0;
      base_ovf = 1'b0;
    end

    sum     = {base_acc[WIDTH-1], base_acc} + {bus.x_i[WIDTH-1], bus.x_i};
    ovf_now = sum[WIDTH] != sum[WIDTH-1];
    new_acc = sum[WIDTH-1:0];
    if (ovf_now && (SAT != 0)) begin
      new_acc = sum[WIDTH] ? ACC_MIN : ACC_MAX;
    end
    new_cnt = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + CNT_W'(1);

    ovf_d = ovf_q;
    for (int k = 0; k < N_CH; k++) begin
      acc_d[k] = acc_q[k];
      cnt_d[k] = cnt_q[k];
      if (32'(bus.ch_i) == k) begin
        if (bus.valid_i) begin
          acc_d[k] = new_acc;
          cnt_d[k] = new_cnt;
          ovf_d[k] = base_ovf | ovf_now;
        end else if (bus.clr_i) begin
          acc_d[k] = '0;
          cnt_d[k] = '0;
          ovf_d[k] = 1'b0;
        end
      end
    end

    valid_d   = bus.valid_i && hit;
    ch_d      = valid_d ? bus.ch_i : ch_q;
    y_d       = valid_d ? new_acc  : y_q;
    out_cnt_d = valid_d ? new_cnt  : out_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_CH; k++) begin
        acc_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      ovf_q     <= '0;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      y_q       <= '0;
      out_cnt_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        acc_q[k] <= acc_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      y_q       <= y_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.ch_o    = ch_q;
  assign bus.y_o     = y_q;
  assign bus.cnt_o   = out_cnt_q;
  assign bus.ovf_o   = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_accum_mchan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_accum_mchan : scoreboard bench, wrap and saturate instances.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_accum_mchan;
  localparam int WIDTH = 8;
  localparam int N_CH  = 3;
  localparam int CNT_W = 4;

  typedef struct {
    int ch;
    int y;
    int cnt;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk_i = ~clk_i;

  accum_mchan_if #(.WIDTH(WIDTH), .N_CH(N_CH), .CNT_W(CNT_W)) if0 ();
  accum_mchan_if #(.WIDTH(WIDTH), .N_CH(N_CH), .CNT_W(CNT_W)) if1 ();

  accum_mchan #(.WIDTH(WIDTH), .N_CH(N_CH), .SAT(0), .CNT_W(CNT_W)) u_wrap (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (if0.slave)
  );

  accum_mchan #(.WIDTH(WIDTH), .N_CH(N_CH), .SAT(1), .CNT_W(CNT_W)) u_sat (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (if1.slave)
  );

  always @(negedge clk_i) begin
    if (if0.valid_o) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL wrap_out unexpected valid_o ch=%0d y=%0d cnt=%0d, required no output",
                 if0.ch_o, if0.y_o, if0.cnt_o);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (int'(if0.ch_o) != e.ch || int'(if0.y_o) != e.y || int'(if0.cnt_o) != e.cnt) begin
          fails++;
          $display("FAIL wrap_out got ch=%0d y=%0d cnt=%0d, required ch=%0d y=%0d cnt=%0d",
                   if0.ch_o, if0.y_o, if0.cnt_o, e.ch, e.y, e.cnt);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (if1.valid_o) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL sat_out unexpected valid_o ch=%0d y=%0d cnt=%0d, required no output",
                 if1.ch_o, if1.y_o, if1.cnt_o);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (int'(if1.ch_o) != e.ch || int'(if1.y_o) != e.y || int'(if1.cnt_o) != e.cnt) begin
          fails++;
          $display("FAIL sat_out got ch=%0d y=%0d cnt=%0d, required ch=%0d y=%0d cnt=%0d",
                   if1.ch_o, if1.y_o, if1.cnt_o, e.ch, e.y, e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic drive(input bit v, input int ch, input int x, input bit clr, input bit r);
    if0.valid_i = v;  if0.ch_i = 2'(ch);  if0.x_i = 8'(x);  if0.clr_i = clr;
    if1.valid_i = v;  if1.ch_i = 2'(ch);  if1.x_i = 8'(x);  if1.clr_i = clr;
    rst_i = r;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // e0 is the wrap-mode result, e1 the saturate-mode result.
  task automatic smp(input int ch, input int x, input bit clr, input int e0, input int e1,
                     input int ec);
    q0.push_back('{ch: ch, y: e0, cnt: ec});
    q1.push_back('{ch: ch, y: e1, cnt: ec});
    drive(1'b1, ch, x, clr, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid0"}, int'(if0.valid_o), 0);
    chk({tag, "_y0"},     int'(if0.y_o),     0);
    chk({tag, "_cnt0"},   int'(if0.cnt_o),   0);
    chk({tag, "_ch0"},    int'(if0.ch_o),    0);
    chk({tag, "_ovf0"},   int'(if0.ovf_o),   0);
    chk({tag, "_valid1"}, int'(if1.valid_o), 0);
    chk({tag, "_y1"},     int'(if1.y_o),     0);
    chk({tag, "_ovf1"},   int'(if1.ovf_o),   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout, required run to complete");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    chk_zero("reset");
    drive(1'b0, 0, 0, 1'b0, 1'b0);

    // Back-to-back accumulation on channel 0.
    smp(0, 5,  1'b0, 5,  5,  1);
    smp(0, 7,  1'b0, 12, 12, 2);
    smp(0, -3, 1'b0, 9,  9,  3);
    idle(1);

    // Clear-only on ch0, then interleave ch0 and ch2.
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    chk("clr_only_no_valid", int'(if0.valid_o), 0);
    smp(0, 1,   1'b0, 1,   1,   1);
    smp(2, 10,  1'b0, 10,  10,  1);
    smp(0, 1,   1'b0, 2,   2,   2);
    smp(2, -20, 1'b0, -10, -10, 2);
    idle(1);
    chk("interleave_ovf0", int'(if0.ovf_o), 0);

    // Overflow on ch1 (untouched so far, so it starts from 0).
    smp(1, 100, 1'b0, 100, 100, 1);
    smp(1, 100, 1'b0, -56, 127, 2);
    idle(1);
    chk("pos_ovf_wrap", int'(if0.ovf_o), 2);
    chk("pos_ovf_sat",  int'(if1.ovf_o), 2);
    smp(1, -128, 1'b1, -128, -128, 1);
    chk("fused_clr_ovf_wrap", int'(if0.ovf_o), 0);
    smp(1, -1, 1'b0, 127, -128, 2);
    idle(1);
    chk("neg_ovf_wrap", int'(if0.ovf_o), 2);
    chk("neg_ovf_sat",  int'(if1.ovf_o), 2);

    // Fused clear on an overflowed channel, then clear-only.
    smp(1, 4, 1'b1, 4, 4, 1);
    chk("fused_clr_ovf_sat", int'(if1.ovf_o), 0);
    smp(1, 127, 1'b0, -125, 127, 2);
    chk("reovf_sticky", int'(if1.ovf_o), 2);
    idle(2);
    chk("ovf_sticky_idle", int'(if0.ovf_o), 2);
    drive(1'b0, 1, 0, 1'b1, 1'b0);
    chk("clr_only_ovf0", int'(if0.ovf_o), 0);
    chk("clr_only_ovf1", int'(if1.ovf_o), 0);
    chk("clr_only_nopulse", int'(if1.valid_o), 0);
    smp(1, 2, 1'b0, 2, 2, 1);

    // Out-of-range channel: sample and clear are ignored.
    drive(1'b1, 3, 50, 1'b0, 1'b0);
    drive(1'b0, 3, 0,  1'b1, 1'b0);
    drive(1'b1, 3, 50, 1'b1, 1'b0);
    chk("oor_no_valid", int'(if0.valid_o), 0);
    smp(0, 1, 1'b0, 3,   3,   3);
    smp(1, 0, 1'b0, 2,   2,   2);
    smp(2, 0, 1'b0, -10, -10, 3);

    // Counter saturation at 15.
    smp(0, 1, 1'b1, 1, 1, 1);
    for (int i = 2; i <= 17; i++) smp(0, 1, 1'b0, i, i, (i > 15) ? 15 : i);
    smp(0, 1, 1'b0, 18, 18, 15);

    // Reset in the middle of a stream; the sample under reset is dropped.
    drive(1'b1, 0, 1, 1'b0, 1'b1);
    chk_zero("midrst");
    smp(0, 6, 1'b0, 6, 6, 1);
    idle(3);

    chk("wrap_queue_drained", q0.size(), 0);
    chk("sat_queue_drained",  q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/accum_mchan.md
ACCUM_MCHAN -- requirements
Module: accum_mchan

Interface
REQ-001 Parameter WIDTH, default 32, accumulator and data width in bits (two's complement, signed).
REQ-002 Parameter N_CH, default 4, number of independent accumulator channels (>=1); CH_W = max(1, clog2(N_CH)).
REQ-003 Parameter SAT, default 0, overflow mode: 0 = wrap modulo 2^WIDTH, 1 = saturate to signed max/min.
REQ-004 Parameter CNT_W, default 8, width of per-channel sample counter.
REQ-005 clk_i  in  1  clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset; one clock; reset is synchronous and active-high.
REQ-007 valid_i  in  1  x_i/ch_i/clr_i carry a sample this cycle.
REQ-008 ch_i  in  CH_W  target channel index.
REQ-009 x_i  in  WIDTH  signed sample to add.
REQ-010 clr_i  in  1  clear target channel (alone, or fused with a sample when valid_i=1).
REQ-011 valid_o  out  1  one-cycle pulse: y_o/ch_o/cnt_o hold a fresh result.
REQ-012 ch_o  out  CH_W  channel of the result.
REQ-013 y_o  out  WIDTH  updated accumulator value of ch_o.
REQ-014 cnt_o  out  CNT_W  samples accumulated into ch_o since its last clear.
REQ-015 ovf_o  out  N_CH  sticky overflow flag per channel, bit k = channel k.

Function
REQ-016 Block SHALL hold N_CH accumulators acc[k], counters cnt[k], flags ovf[k]; no backpressure, one sample accepted every cycle.
REQ-017 valid_i=1, clr_i=0, ch_i<N_CH: sum = acc[ch_i] + x_i at WIDTH+1 bits; acc[ch_i] <= result next edge.
REQ-018 valid_i=1, clr_i=1: result = x_i (old acc discarded); cnt[ch_i] <= 1; ovf[ch_i] <= 0.
REQ-019 Signed overflow SHALL be flagged when operand signs match and truncated sum sign differs.
REQ-020 On overflow, SAT=0: store truncated sum; SAT=1: store 2^(WIDTH-1)-1 if positive overflow, -2^(WIDTH-1) if negative; both modes set ovf[ch_i] <= 1.
REQ-021 ovf[k] SHALL stay set until clr_i on channel k or rst_i.
REQ-022 cnt[ch_i] SHALL increment per accepted sample, saturating at 2^CNT_W-1.
REQ-023 Latency one cycle: valid_o=1, ch_o=ch_i, y_o=new acc, cnt_o=new cnt in the cycle after acceptance; valid_o=0 otherwise, y_o/ch_o/cnt_o hold last values.
REQ-024 Back-to-back samples to the same channel SHALL each see the previous update (no lost sums, no stall).
REQ-025 valid_i=0, clr_i=1, ch_i<N_CH: acc, cnt, ovf of ch_i cleared to 0 next edge; no valid_o pulse.
REQ-026 ch_i>=N_CH (non-power-of-2 N_CH): sample and clear SHALL be ignored; no state change, no valid_o.
REQ-027 Channels other than ch_i SHALL never change in a given cycle.
REQ-028 ovf_o SHALL reflect register state directly (updated same edge as acc).

Reset
REQ-029 rst_i=1 at a rising edge SHALL zero all acc, cnt, ovf, valid_o, y_o, ch_o, cnt_o; rst_i overrides valid_i/clr_i.
REQ-030 Reset mid-stream: a sample presented with rst_i=1 SHALL be dropped; no valid_o the following cycle.

Verification (WIDTH=8, N_CH=3, CNT_W=4)
REQ-031 Reset, then ch0 samples 5, 7, -3 back-to-back -> valid_o three consecutive cycles, y_o 5, 12, 9, cnt_o 1, 2, 3.
REQ-032 SAT=0: ch1 samples 100, 100 -> y_o 100 then -56, ovf_o[1]=1; SAT=1 same stimulus -> y_o 127, ovf_o[1]=1; ch1 -128, -1 with SAT=1 -> -128.
REQ-033 Interleave ch0 +1, ch2 +10, ch0 +1, ch2 -20 -> y_o 1, 10, 2, -10; ch1 untouched (acc 0, ovf 0).
REQ-034 Channel with ovf=1: clr_i+valid_i, x_i=4 -> y_o 4, cnt_o 1, ovf bit cleared; clr_i alone -> no valid_o, next sample x=2 gives y_o 2.
REQ-035 ch_i=3 (out of range) with valid_i -> no valid_o, no state change; 17 samples on ch0 -> cnt_o saturates at 15.
REQ-036 rst_i asserted during a continuous ch0 stream -> all outputs 0 next cycle, first post-reset sample x=6 gives y_o 6, cnt_o 1.
